// File: rtl/ctrl_pipe_if.sv
// Handshake, stall/flush and per-stage observation bundle for ctrl_pipe.
// The pipeline side uses the slave modport; the decode/hazard side uses master.
interface ctrl_pipe_if #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      in_ready;
    logic [STAGES-1:0]         stall;
    logic [STAGES-1:0]         flush;
    logic [STAGES*WIDTH-1:0]   stage_data;
    logic [STAGES-1:0]         stage_valid;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic [OCC_W-1:0]          occ;

    modport master (
        output in_valid, in_data, stall, flush,
        input  in_ready, stage_data, stage_valid, out_data, out_valid, occ
    );

    modport slave (
        input  in_valid, in_data, stall, flush,
        output in_ready, stage_data, stage_valid, out_data, out_valid, occ
    );
endinterface

// File: rtl/ctrl_pipe.sv
// Generic control-bundle pipeline (decode to writeback) with stall, flush and bubbles.
// Define CTRL_PIPE_SQUEEZE_EN to let bubbles be overwritten while downstream is stalled.
module ctrl_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 3
) (
    input  logic         clk,
    input  logic         reset,
    ctrl_pipe_if.slave   bus
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic [WIDTH-1:0]  stageData [STAGES];
    logic [STAGES-1:0] stageValid;
    logic [OCC_W-1:0]  occReg;

    logic [WIDTH-1:0]  prevData  [STAGES];
    logic [STAGES-1:0] prevValid;
    logic [WIDTH-1:0]  nxtData   [STAGES];
    logic [STAGES-1:0] nxtValid;
    logic [STAGES-1:0] hold;

    function automatic logic [OCC_W-1:0] popCount(input logic [STAGES-1:0] v);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            cnt = cnt + OCC_W'(v[i]);
        end
        return cnt;
    endfunction

    // Hold chain resolved from the last stage back towards the input.
    always_comb begin
        hold = '0;
        hold[STAGES-1] = bus.stall[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
`ifdef CTRL_PIPE_SQUEEZE_EN
            hold[k] = bus.stall[k] | (hold[k+1] & stageValid[k]);
`else
            hold[k] = bus.stall[k] | hold[k+1];
`endif
        end
    end

    // Predecessor of each stage; an invalid input is forced to an all-zero bubble.
    always_comb begin
        prevData[0]  = bus.in_valid ? bus.in_data : '0;
        prevValid    = '0;
        prevValid[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            prevData[k]  = stageData[k-1];
            prevValid[k] = stageValid[k-1];
        end
    end

    always_comb begin
        nxtValid = '0;
        for (int k = 0; k < STAGES; k++) begin
            nxtData[k] = '0;
            if (bus.flush[k]) begin
                nxtData[k]  = '0;
                nxtValid[k] = 1'b0;
            end else if (hold[k]) begin
                nxtData[k]  = stageData[k];
                nxtValid[k] = stageValid[k];
            end else begin
                nxtData[k]  = prevData[k];
                nxtValid[k] = prevValid[k];
            end
        end
    end

    // Stage registers; reset clears data too so every control field reads as a NOP.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stageValid <= '0;
            occReg     <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stageData[k] <= '0;
            end
        end else begin
            stageValid <= nxtValid;
            occReg     <= popCount(nxtValid);
            for (int k = 0; k < STAGES; k++) begin
                stageData[k] <= nxtData[k];
            end
        end
    end

    always_comb begin
        bus.stage_data = '0;
        for (int k = 0; k < STAGES; k++) begin
            bus.stage_data[k*WIDTH +: WIDTH] = stageData[k];
        end
    end

    assign bus.stage_valid = stageValid;
    assign bus.out_data    = stageData[STAGES-1];
    assign bus.out_valid   = stageValid[STAGES-1];
    assign bus.occ         = occReg;
    assign bus.in_ready    = ~hold[0];
endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe (STAGES=3, WIDTH=16); expectations follow
// CTRL_PIPE_SQUEEZE_EN when the bench is built with that macro.
module tb_ctrl_pipe;
    localparam int W = 16;
    localparam int S = 3;

    logic clk;
    logic reset;
    int   nChecks;
    int   nPass;

    ctrl_pipe_if #(.WIDTH(W), .STAGES(S)) bus ();

    ctrl_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            nPass++;
        end
    endtask

    // Advance one edge, then let registered outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d,
                         input logic [S-1:0] st, input logic [S-1:0] fl);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.stall    = st;
        bus.flush    = fl;
        #1;
    endtask

    initial begin
        nChecks = 0;
        nPass   = 0;
        reset   = 1'b0;
        drive(1'b0, 16'h0000, 3'b000, 3'b000);

        // Reset for two edges
        tick();
        tick();
        checkEq("rst_valid", 64'(bus.stage_valid), 64'h0);
        checkEq("rst_occ", 64'(bus.occ), 64'h0);
        checkEq("rst_out_data", 64'(bus.out_data), 64'h0);
        checkEq("rst_out_valid", 64'(bus.out_valid), 64'h0);
        checkEq("rst_data", 64'(bus.stage_data), 64'h0);
        checkEq("rst_in_ready", 64'(bus.in_ready), 64'h1);

        // Fill with 1,2,3
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 16'(i), 3'b000, 3'b000);
            checkEq($sformatf("fill_in_ready_%0d", i), 64'(bus.in_ready), 64'h1);
            tick();
        end
        checkEq("fill_out_valid", 64'(bus.out_valid), 64'h1);
        checkEq("fill_out_data", 64'(bus.out_data), 64'h1);
        checkEq("fill_occ", 64'(bus.occ), 64'h3);
        checkEq("fill_stage_data", 64'(bus.stage_data), 64'h0001_0002_0003);

        // Load 0x0C, 0x0B, 0x0A then stall the last stage
        drive(1'b1, 16'h000C, 3'b000, 3'b000); tick();
        drive(1'b1, 16'h000B, 3'b000, 3'b000); tick();
        drive(1'b1, 16'h000A, 3'b000, 3'b000); tick();
        checkEq("full_stage_data", 64'(bus.stage_data), 64'h000C_000B_000A);
        drive(1'b1, 16'h00FF, 3'b100, 3'b000);
        checkEq("stall_in_ready", 64'(bus.in_ready), 64'h0);
        tick();
        tick();
        checkEq("stall_stage_data", 64'(bus.stage_data), 64'h000C_000B_000A);
        checkEq("stall_valid", 64'(bus.stage_valid), 64'h7);
        checkEq("stall_occ", 64'(bus.occ), 64'h3);
        drive(1'b0, 16'h0000, 3'b000, 3'b000);
        checkEq("resume_out0", 64'(bus.out_data), 64'h000C);
        tick();
        checkEq("resume_out1", 64'(bus.out_data), 64'h000B);
        checkEq("resume_occ1", 64'(bus.occ), 64'h2);
        tick();
        checkEq("resume_out2", 64'(bus.out_data), 64'h000A);
        checkEq("resume_occ2", 64'(bus.occ), 64'h1);
        tick();
        checkEq("drain_out_valid", 64'(bus.out_valid), 64'h0);
        checkEq("drain_occ", 64'(bus.occ), 64'h0);

        // Flush stage 1 while 0x0005 moves into it
        drive(1'b1, 16'h0003, 3'b000, 3'b000); tick();
        drive(1'b1, 16'h0004, 3'b000, 3'b000); tick();
        drive(1'b1, 16'h0005, 3'b000, 3'b000); tick();
        checkEq("preflush_occ", 64'(bus.occ), 64'h3);
        drive(1'b1, 16'h0006, 3'b000, 3'b010);
        tick();
        checkEq("flush_valid", 64'(bus.stage_valid), 64'h5);
        checkEq("flush_stage_data", 64'(bus.stage_data), 64'h0004_0000_0006);
        checkEq("flush_occ", 64'(bus.occ), 64'h2);

        // Flush and stall stage 1 together
        drive(1'b1, 16'h0007, 3'b000, 3'b000); tick();
        checkEq("pre_fs_stage_data", 64'(bus.stage_data), 64'h0000_0006_0007);
        drive(1'b1, 16'h0008, 3'b010, 3'b010);
        checkEq("fs_in_ready", 64'(bus.in_ready), 64'h0);
        tick();
        checkEq("fs_valid", 64'(bus.stage_valid), 64'h5);
        checkEq("fs_stage_data", 64'(bus.stage_data), 64'h0006_0000_0007);
        checkEq("fs_occ", 64'(bus.occ), 64'h2);

        // Bubble in stage 1 with the last stage stalled
        drive(1'b1, 16'h0008, 3'b100, 3'b000);
`ifdef CTRL_PIPE_SQUEEZE_EN
        checkEq("sq_in_ready", 64'(bus.in_ready), 64'h1);
        tick();
        checkEq("sq_stage_data", 64'(bus.stage_data), 64'h0006_0007_0008);
        checkEq("sq_valid", 64'(bus.stage_valid), 64'h7);
        checkEq("sq_occ", 64'(bus.occ), 64'h3);
        #1;
        checkEq("sq_full_in_ready", 64'(bus.in_ready), 64'h0);
`else
        checkEq("nosq_in_ready", 64'(bus.in_ready), 64'h0);
        tick();
        checkEq("nosq_stage_data", 64'(bus.stage_data), 64'h0006_0000_0007);
        checkEq("nosq_valid", 64'(bus.stage_valid), 64'h5);
        checkEq("nosq_occ", 64'(bus.occ), 64'h2);
`endif

        // Refill, then reset mid-stream with stall/flush asserted
        drive(1'b1, 16'h0011, 3'b000, 3'b000); tick();
        drive(1'b1, 16'h0012, 3'b000, 3'b000); tick();
        drive(1'b1, 16'h0013, 3'b000, 3'b000); tick();
        checkEq("refill_occ", 64'(bus.occ), 64'h3);
        checkEq("refill_stage_data", 64'(bus.stage_data), 64'h0011_0012_0013);
        reset = 1'b0;
        drive(1'b1, 16'h0014, 3'b111, 3'b010);
        checkEq("rst_stall_in_ready", 64'(bus.in_ready), 64'h0);
        tick();
        checkEq("midrst_valid", 64'(bus.stage_valid), 64'h0);
        checkEq("midrst_occ", 64'(bus.occ), 64'h0);
        checkEq("midrst_out_data", 64'(bus.out_data), 64'h0);
        checkEq("midrst_stage_data", 64'(bus.stage_data), 64'h0);

        // First accept after reset reaches stage 0 only
        reset = 1'b1;
        drive(1'b1, 16'h0021, 3'b000, 3'b000);
        tick();
        checkEq("post_rst_valid", 64'(bus.stage_valid), 64'h1);
        checkEq("post_rst_stage_data", 64'(bus.stage_data), 64'h0000_0000_0021);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
